// File: rtl/counter_pkg.sv
// Shared types and constants for the BCD timer: state encoding and decade-digit limits.
package counter_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    // Next value of one decade digit when it is told to advance.
    function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] q);
        return (q >= BCD_MAX) ? '0 : q + 1'b1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade (0-9) counter digit with synchronous clear and increment enable.
// Latency: q updates one edge after inc/clr. Backpressure: none, inc is a strobe.
// Behaviour: clr wins over inc; at_max flags 9 so the parent can build the carry chain.
module bcd_digit
    import counter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             at_max
);

    logic [BCD_W-1:0] q_q;
    logic [BCD_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = bcd_next(q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign at_max = (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Run/pause/stop controller over a chain of BCD digits with target match and wrap report.
// Latency: commands act at the next edge; done/wrap are registered one-cycle pulses.
// Backpressure: none; ticks arriving outside RUN (or on a match/stop cycle) are dropped.
module bcd_timer_ctrl
    import counter_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic [BCD_W*DIGITS-1:0] target,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    running,
    output logic                    done,
    output logic                    wrap,
    output logic [1:0]              state
);

    timer_state_t state_q, state_d;
    logic         done_q, done_d;
    logic         wrap_q, wrap_d;

    logic              inc_en;
    logic              digit_clr;
    logic              match;
    logic              all_max;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] carry;

    // Digit i advances only when every lower digit sits at 9.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign carry[i] = inc_en;
        end else begin : g_upper
            assign carry[i] = carry[i-1] & at_max[i-1];
        end

        bcd_digit u_digit (
            .clk    (clk),
            .reset  (reset),
            .clr    (digit_clr),
            .inc    (carry[i]),
            .q      (count[BCD_W*i +: BCD_W]),
            .at_max (at_max[i])
        );
    end

    // Count digits never exceed 9, so a target with an illegal digit can never match.
    assign match   = (count == target);
    assign all_max = &at_max;

    always_comb begin
        state_d   = state_q;
        inc_en    = 1'b0;
        digit_clr = 1'b0;
        done_d    = 1'b0;
        wrap_d    = 1'b0;

        if (clear) begin
            state_d   = IDLE;
            digit_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!stop && start) state_d = RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (match) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (tick) begin
                        inc_en = 1'b1;
                        wrap_d = all_max;
                    end
                end
                PAUSE: begin
                    if (!stop && start) state_d = RUN;
                end
                DONE: begin
                    // Pause is meaningless once finished; start restarts from zero.
                    if (start) begin
                        state_d   = RUN;
                        digit_clr = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign running = (state_q == RUN);
    assign done    = done_q;
    assign wrap    = wrap_q;
    assign state   = state_q;

endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Run/pause/stop controller for a chain of decade (BCD 0–9) counter digits. It forms a multi-digit stopwatch/interval timer:
- Advances the digit chain on an external `tick` strobe.
- Stops when the count matches a programmable BCD target.
- Handles start/stop/clear commands.
- Reports wrap-around of the full chain.

It sits between the prescaler that produces `tick` and any block that consumes elapsed-time or terminal-count events.

## Interface
Parameters:
- `DIGITS`, default 4: number of cascaded BCD digits (1–8).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `tick`  in  1  count strobe; one increment per cycle where it is high and the block is running.
- `start`  in  1  start or resume command, level-sampled each cycle.
- `stop`  in  1  pause command.
- `clear`  in  1  zero the count and return to IDLE.
- `target`  in  4*DIGITS  BCD terminal value; digit i is bits [4i+3:4i].
- `count`  out  4*DIGITS  current BCD count, registered.
- `running`  out  1  high while state is RUN.
- `done`  out  1  one-cycle pulse on entry to DONE.
- `wrap`  out  1  one-cycle pulse when the count rolls from all-9s to all-0s.
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Reset values:
  - `count`=0, `state`=IDLE.
  - `running`, `done` and `wrap` are all 0.
- Command priority, highest first: `reset` > `clear` > `stop` > `start` > `tick`.
- FSM:
  - IDLE: `start` → RUN. `count` holds at 0.
  - RUN:
    - `stop` → PAUSE.
    - Otherwise, if `count`==`target`: go to DONE, no increment.
    - Otherwise, if `tick`: increment.
  - PAUSE: `start` → RUN. `count` holds; `tick` is ignored.
  - DONE: `count` holds. `start` → `count`=0 and state RUN (restart). `stop` has no effect.
  - `clear`, from any state → `count`=0, state IDLE. `done` and `wrap` stay 0 that cycle.
- Increment rule:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and generates a carry into the next digit.
  - Digit i increments only if all lower digits are 9.
- Wrap: when all digits are 9 and an increment occurs (RUN, `tick`, no match), `count` becomes 0 and `wrap` pulses. State stays RUN.
- `target` is compared combinationally against the registered `count` every RUN cycle.
  - A `target` containing a digit >9 never matches. The timer then runs and wraps indefinitely.
  - `target` may change at any time; the new value takes effect on the next compare.
- Digit values >9 never appear on `count`.

## Timing
- `start` sampled at edge N → `state`=RUN and `running`=1 after edge N.
- The first increment can occur at edge N+1, if `tick` is high in that cycle.
- Match latency:
  - `count`==`target` during RUN cycle K → DONE after edge K.
  - `done` is high exactly that one cycle (the first DONE cycle).
  - A `tick` in cycle K is dropped.
- Start with `count` already equal to `target` (e.g. target=0 from IDLE): RUN for one cycle, then DONE.
- `stop` and `tick` in the same RUN cycle: PAUSE, no increment.
- `clear` and `start` in the same cycle: IDLE, `count`=0.
- `reset` mid-run: all outputs return to reset values after the edge; no `done` or `wrap` pulse.
- `wrap` is registered: high in the cycle after the rollover edge, coincident with `count`=0.

## Structure
- Shared package `counter_pkg`:
  - State enumeration `timer_state_t` (IDLE, RUN, PAUSE, DONE).
  - Constants `BCD_MAX`=4'd9 and `BCD_W`=4.
- Natural sub-module: `bcd_digit`.
  - One decade digit with inputs `clk`, `reset`, `clr`, `inc`.
  - Outputs 4-bit `q` and `at_max`.
  - `bcd_timer_ctrl` generates `DIGITS` instances, chains `inc` from the AND of lower `at_max` signals, and holds the FSM, compare and pulse registers.

## Test plan
All scenarios use DIGITS=2.
1. Reset, then `tick` held high, `start` pulsed, target=8'h12 → `count` steps 00..12 over 12 tick cycles. DONE is entered and `done` pulses once. `count` holds at 12 afterwards.
2. Carry: target=8'hFF (never matches), run from 00 with continuous `tick` → 09→10, 99→00 with a single `wrap` pulse; `running` stays 1.
3. Pause: at count=8'h05, assert `stop` together with `tick` → PAUSE with `count` 05. 10 ticks later `count` is still 05. `start` → resumes; 06 appears on the next tick.
4. Target 00 from IDLE: pulse `start` → one RUN cycle, then DONE with `done`=1 and `count`=00.
5. Priority: assert `clear`+`start` at count=8'h37 → IDLE, `count`=00, no `done`. Then `start` in DONE → `count`=00 and RUN.
6. Assert `reset` mid-run at count=8'h44 → after the edge `count`=00, IDLE, `running`/`done`/`wrap`=0.
